// File: rtl/cache_port_arbiter.sv
// cache_port_arbiter: arbitrates NUM_REQ requester ports onto a single cache controller port.
// Optional build macro: ARB_ROUND_ROBIN_EN selects round-robin arbitration (default: fixed priority, lowest index wins).
// Ports:
//   clk, rst                 clock and asynchronous active-high reset
//   req, req_rw              per-requester request level and direction (1=write)
//   req_addr, req_wdata      flattened per-requester address / write data, requester k at [ADDR_W*k +: ADDR_W]
//   ack, rdata               one-cycle completion pulse per requester and the last read data
//   cache_address, cache_data_in, cache_rw, cache_req   request towards the cache controller
//   cache_data_out, cache_ready                         response from the cache controller
//   busy, grant_id           arbiter activity and current / most recent winner
module cache_port_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*ADDR_W-1:0] req_wdata,
    input  logic [NUM_REQ-1:0]      req_rw,
    output logic [NUM_REQ-1:0]      ack,
    output logic [ADDR_W-1:0]       rdata,
    output logic [ADDR_W-1:0]       cache_address,
    output logic [ADDR_W-1:0]       cache_data_in,
    output logic                    cache_rw,
    output logic                    cache_req,
    input  logic [ADDR_W-1:0]       cache_data_out,
    input  logic                    cache_ready,
    output logic                    busy,
    output logic [1:0]              grant_id
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    state_t state, state_nxt;
    logic [1:0] winner;
    logic [3:0] req_x;
    logic [3:0] rw_x;
    logic [ADDR_W-1:0] addr_a [4];
    logic [ADDR_W-1:0] wdata_a [4];
    logic grant;

    // Widen to four slots so a 2-bit index is always in range; absent ports read as idle.
    always_comb begin
        req_x = 4'(req);
        rw_x  = 4'(req_rw);
        for (int k = 0; k < 4; k++) begin
            addr_a[k]  = '0;
            wdata_a[k] = '0;
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            addr_a[k]  = req_addr[k*ADDR_W +: ADDR_W];
            wdata_a[k] = req_wdata[k*ADDR_W +: ADDR_W];
        end
    end

    assign grant = (state == IDLE) && (|req);

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0] rr_ptr;
    logic [1:0] idx;

    // Scan from rr_ptr+1 downwards in distance so the closest requester wins.
    always_comb begin
        winner = '0;
        idx    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = 2'((int'(rr_ptr) + 1 + i) % NUM_REQ);
            if (req_x[idx]) winner = idx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_ptr <= 2'(NUM_REQ - 1);
        else if (grant) rr_ptr <= winner;
    end
`else
    always_comb begin
        winner = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_x[i]) winner = 2'(i);
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  state_nxt = (|req) ? ISSUE : IDLE;
            ISSUE: state_nxt = WAIT;
            WAIT:  state_nxt = cache_ready ? RESP : WAIT;
            RESP:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign cache_req = (state == ISSUE);
    assign busy      = (state != IDLE);
    assign ack       = (state == RESP) ? (NUM_REQ'(1) << grant_id) : '0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cache_address <= '0;
            cache_data_in <= '0;
            cache_rw      <= 1'b0;
            grant_id      <= '0;
            rdata         <= '0;
        end else begin
            if (grant) begin
                cache_address <= addr_a[winner];
                cache_data_in <= wdata_a[winner];
                cache_rw      <= rw_x[winner];
                grant_id      <= winner;
            end
            if (state == WAIT && cache_ready && !cache_rw) rdata <= cache_data_out;
        end
    end
endmodule

// File: tb/tb_cache_port_arbiter.sv
// tb_cache_port_arbiter: self-checking bench for cache_port_arbiter (table, random vs. model, corner sequences).
`timescale 1ns/1ps
module tb_cache_port_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [3:0]  req_rw = '0;
    logic [31:0] addr_m [4];
    logic [31:0] wdata_m [4];
    logic [127:0] req_addr, req_wdata;
    logic [3:0]  ack;
    logic [31:0] rdata, cache_address, cache_data_in;
    logic        cache_rw, cache_req, busy;
    logic [31:0] cache_data_out = '0;
    logic        cache_ready = 1'b0;
    logic [1:0]  grant_id;

    int total = 0;
    int passed = 0;
    int cyc = 0;
    int last_strobe = -100;
    int model_last = 3;
    logic [31:0] model_rdata = '0;

    assign req_addr  = {addr_m[3], addr_m[2], addr_m[1], addr_m[0]};
    assign req_wdata = {wdata_m[3], wdata_m[2], wdata_m[1], wdata_m[0]};

    cache_port_arbiter #(.NUM_REQ(4), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rw(req_rw), .ack(ack), .rdata(rdata), .cache_address(cache_address),
        .cache_data_in(cache_data_in), .cache_rw(cache_rw), .cache_req(cache_req),
        .cache_data_out(cache_data_out), .cache_ready(cache_ready), .busy(busy),
        .grant_id(grant_id)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (!rst && ack != 4'd0) check("ack_onehot", 32'($onehot(ack)), 32'd1);
        if (!rst && cache_req) begin
            check("strobe_gap_ge3", 32'((cyc - last_strobe) >= 3), 32'd1);
            last_strobe = cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference arbitration: round robin from the last winner, or lowest index.
    function automatic int pick(input logic [3:0] r, input int last);
`ifdef ARB_ROUND_ROBIN_EN
        for (int i = 1; i <= 4; i++) if (r[(last + i) % 4]) return (last + i) % 4;
`else
        for (int i = 0; i < 4; i++) if (r[i]) return i;
`endif
        return 0;
    endfunction

    task automatic reset_dut();
        rst = 1'b1;
        req = '0;
        cache_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_last = 3;
        model_rdata = '0;
    endtask

    logic [3:0] obs_ack;
    logic [31:0] obs_rdata;
    logic [1:0] obs_grant;

    task automatic run_txn(input logic [3:0] r, input logic [3:0] rw, input int lat,
                           input logic [31:0] cdata, input bit hold, input bit drop_early);
        int g;
        int n;
        g = pick(r, model_last);
        model_last = g;
        req = r;
        req_rw = rw;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cache_req && n < 20);
        check("strobe_seen", 32'(cache_req), 32'd1);
        check("grant_id", 32'(grant_id), 32'(g));
        check("cache_address", cache_address, addr_m[g]);
        check("cache_data_in", cache_data_in, wdata_m[g]);
        check("cache_rw", 32'(cache_rw), 32'(rw[g]));
        for (int c = 1; c <= lat; c++) begin
            @(negedge clk);
            if (c == 1 && drop_early) req = '0;
            check("wait_busy", 32'({busy, cache_req, ack}), 32'h20);
            check("wait_addr_stable", cache_address, addr_m[g]);
            check("wait_wdata_stable", cache_data_in, wdata_m[g]);
            check("wait_rw_stable", 32'(cache_rw), 32'(rw[g]));
            if (c == lat) begin
                cache_ready = 1'b1;
                cache_data_out = cdata;
            end
        end
        @(negedge clk);
        cache_ready = 1'b0;
        if (!rw[g]) model_rdata = cdata;
        obs_ack = ack;
        obs_rdata = rdata;
        obs_grant = grant_id;
        check("ack", 32'(ack), 32'(4'b0001 << g));
        check("rdata", rdata, model_rdata);
        if (!hold) req = '0;
    endtask

    typedef struct {
        logic [3:0]  r;
        logic [3:0]  rw;
        int          lat;
        logic [31:0] cdata;
        logic [3:0]  exp_ack;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t tbl [6];
    int exp_order [5];
    logic [31:0] pre_rdata;

    initial begin
        for (int k = 0; k < 4; k++) begin
            addr_m[k]  = 32'h40 + 32'h100 * k;
            wdata_m[k] = 32'hA000_0000 + k;
        end
        tbl[0] = '{4'b0001, 4'b0000, 5, 32'h0000_1234, 4'b0001, 32'h0000_1234};
        tbl[1] = '{4'b0100, 4'b0100, 1, 32'h0000_5555, 4'b0100, 32'h0000_1234};
        tbl[2] = '{4'b1000, 4'b0000, 2, 32'h0000_CAFE, 4'b1000, 32'h0000_CAFE};
        tbl[3] = '{4'b0010, 4'b0010, 3, 32'h0000_7777, 4'b0010, 32'h0000_CAFE};
        tbl[4] = '{4'b0010, 4'b0000, 1, 32'h0000_0BAD, 4'b0010, 32'h0000_0BAD};
        tbl[5] = '{4'b1000, 4'b1000, 4, 32'h0000_FFFF, 4'b1000, 32'h0000_0BAD};

        @(negedge clk);
        check("reset_outputs", {ack, busy, cache_req, cache_rw, grant_id, 23'd0}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_address", cache_address, 32'd0);
        reset_dut();

        for (int i = 0; i < 6; i++) begin
            run_txn(tbl[i].r, tbl[i].rw, tbl[i].lat, tbl[i].cdata, 1'b0, 1'b0);
            check("tbl_ack", 32'(obs_ack), 32'(tbl[i].exp_ack));
            check("tbl_rdata", obs_rdata, tbl[i].exp_rdata);
        end

        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 4; k++) begin
                addr_m[k]  = $urandom;
                wdata_m[k] = $urandom;
            end
            run_txn(4'($urandom_range(1, 15)), 4'($urandom), $urandom_range(1, 4), $urandom, 1'b0, 1'b0);
        end

        // All four held high, latency 2.
        reset_dut();
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{0, 1, 2, 3, 0};
`else
        exp_order = '{0, 0, 0, 0, 0};
`endif
        for (int i = 0; i < 5; i++) begin
            run_txn(4'b1111, 4'b0000, 2, 32'h100 + i, 1'b1, 1'b0);
            check("held_grant_order", 32'(obs_grant), 32'(exp_order[i]));
        end
        req = '0;

        // Write from requester 2 that drops req while waiting; rdata must survive.
        reset_dut();
        run_txn(4'b0001, 4'b0000, 1, 32'h0000_1111, 1'b0, 1'b0);
        addr_m[2] = 32'h0000_0100;
        wdata_m[2] = 32'hDEAD_BEEF;
        pre_rdata = rdata;
        run_txn(4'b0100, 4'b0100, 3, 32'h5A5A_5A5A, 1'b0, 1'b1);
        check("write_ack2", 32'(obs_ack), 32'h4);
        check("write_rdata_kept", obs_rdata, pre_rdata);

        // Reset in the middle of a wait aborts without ack.
        reset_dut();
        addr_m[1] = 32'h0000_0200;
        req = 4'b0010;
        req_rw = 4'b0000;
        for (int n = 0; n < 20 && !cache_req; n++) @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_outputs", {ack, busy, cache_req, cache_rw, grant_id, 23'd0}, 32'd0);
        check("midrst_address", cache_address, 32'd0);
        check("midrst_data_in", cache_data_in, 32'd0);
        check("midrst_rdata", rdata, 32'd0);
        @(negedge clk);
        check("midrst_ack_held", 32'(ack), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_last = 3;
        model_rdata = '0;
        run_txn(4'b0010, 4'b0000, 2, 32'h0000_ABCD, 1'b0, 1'b0);
        check("midrst_reissue_ack", 32'(obs_ack), 32'h2);

        // Spurious cache_ready while idle.
        @(negedge clk);
        @(negedge clk);
        cache_ready = 1'b1;
        cache_data_out = 32'h9999_9999;
        @(negedge clk);
        cache_ready = 1'b0;
        check("spurious_state", {ack, busy, cache_req, 26'd0}, 32'd0);
        check("spurious_rdata", rdata, 32'h0000_ABCD);
        @(negedge clk);
        check("spurious_after", {ack, busy, cache_req, 26'd0}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
